dmem_mmio: RTL
==============

Name: dmem_mmio

Overview:
- Data-memory stage directly downstream of the single-cycle datapath.
- Consumes ALUResult (address), WriteData and MemWrite; returns ReadData in the same cycle for the MemtoReg result mux.
- Holds a word RAM plus a small memory-mapped I/O window: LED register, synchronized switches, and a compare/match timer for board-level programs.

Parameters:
- RAM_WORDS, 64, number of 32-bit RAM words (power of 2, at most 1024).
- TIMER_W, 32, timer counter/compare width (at most 32).
- SW_W, 10, switch input width.
- LED_W, 10, LED output width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- MemWrite  in  1  store strobe from the control unit.
- Addr  in  32  byte address (ALUResult); Addr[1:0] ignored, word access only.
- WriteData  in  32  store data from the register file.
- ReadData  out  32  load data, combinational from Addr.
- sw  in  SW_W  asynchronous board switches.
- led  out  LED_W  LED register.
- timer_match  out  1  timer match flag, level.

Behaviour:
- Address map (word aligned):
  - RAM: 0x0000_0000 up to RAM_WORDS*4-1.
  - LED: 0x0000_1000, RW, low LED_W bits.
  - SW: 0x0000_1004, RO, zero-extended.
  - TCNT: 0x0000_1008, RW.
  - TCMP: 0x0000_100C, RW.
  - TCTRL: 0x0000_1010. Bit0 EN, RW. Bit1 CLR_ON_MATCH, RW. Bit2 MATCH: read returns the flag; writing 1 clears it (W1C).
- Unmapped addresses: reads return 0; writes are ignored.
- Register reads are zero-extended above their width.
- Reads: ReadData is combinational from Addr and current state, with zero-cycle latency. MemWrite does not gate reads.
- Writes: take effect at the rising clk edge when MemWrite=1. A same-cycle read of the written location returns the old value.
- RAM: indexed by Addr[log2(RAM_WORDS)+1:2] within the RAM range. Not reset; contents are X until written.
- Reset (reset=0, asynchronous):
  - led=0, TCNT=0, TCMP=all-ones, TCTRL=0, timer_match=0.
  - Switch synchronizer flops = 0.
  - ReadData follows the reset register values.
  - Reset asserted mid-operation drops any pending write.
- Switches: 2-flop synchronizer. The SW read reflects a sw change 2 clk edges later.
- Timer, evaluated every edge:
  - EN=1 and TCNT==TCMP: MATCH is set. TCNT loads 0 if CLR_ON_MATCH=1, otherwise TCNT+1.
  - EN=1 and no match: TCNT increments, wrapping from 2^TIMER_W-1 to 0.
  - EN=0: TCNT holds, and MATCH is not set.
- Timer priorities:
  - A CPU write to TCNT overrides the increment/clear in that cycle.
  - A CPU write to TCTRL updates EN/CLR_ON_MATCH for the next edge. The current edge uses the old EN.
  - MATCH set and W1C clear in the same cycle: set wins.
  - timer_match = MATCH bit.

Decomposition:
- Package dmem_mmio_pkg holds:
  - address constants: ADDR_LED, ADDR_SW, ADDR_TCNT, ADDR_TCMP, ADDR_TCTRL, MMIO_BASE;
  - TCTRL bit indices: EN=0, CLR=1, MATCH=2;
  - a typedef enum for address-decode select: SEL_RAM, SEL_LED, SEL_SW, SEL_TCNT, SEL_TCMP, SEL_TCTRL, SEL_NONE.
- One natural sub-module: mmio_timer (TCNT/TCMP/TCTRL registers, match logic, write ports).
- RAM array, decode, LED register and synchronizer stay in the top level.

Test Plan:
- Reset, then read 0x1000, 0x1008, 0x100C, 0x1010 -> ReadData = 0, 0, 0xFFFF_FFFF, 0; led=0; timer_match=0.
- Write 0xDEAD_BEEF to 0x0000_0010, then read 0x0000_0010 and 0x0000_0013 -> both return 0xDEAD_BEEF. Read during the write cycle -> old value. Read 0x0000_2000 -> 0.
- Set sw=0x2A5 -> SW read stays 0 after 1 edge and reads 0x0000_02A5 after 2 edges. Write 0x3FF to 0x1000 -> led=0x3FF.
- TCMP=5, TCTRL=0b011 -> TCNT counts 0..5.
  - The edge at TCNT==5 sets timer_match=1 and TCNT=0; counting repeats with period 6.
  - Write 0b111 to TCTRL on a non-match cycle -> flag clears.
  - Write 0b111 on a match cycle -> flag stays 1.
- TCNT=0xFFFF_FFFF, TCMP=3, TCTRL=0b001 -> TCNT wraps to 0 then 1, 2, 3. Match sets the flag and TCNT continues to 4. Writing TCNT=100 in a counting cycle -> TCNT=100 next cycle, not 101.
- Assert reset asynchronously mid-count with MemWrite=1 to LED -> led, TCNT and flags go to reset values immediately. The write is lost, and RAM is unchanged at previously written addresses.

Source files
------------

// File: rtl/dmem_mmio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_mmio_pkg
// Description : Shared constants and helpers for the data-memory / MMIO stage.
//               Holds the MMIO address map, the TCTRL bit positions, the
//               address-decode select type and the decode function.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_mmio_pkg;

    // MMIO window, byte addresses (word aligned)
    localparam logic [31:0] MMIO_BASE  = 32'h0000_1000;
    localparam logic [31:0] ADDR_LED   = MMIO_BASE + 32'h0;
    localparam logic [31:0] ADDR_SW    = MMIO_BASE + 32'h4;
    localparam logic [31:0] ADDR_TCNT  = MMIO_BASE + 32'h8;
    localparam logic [31:0] ADDR_TCMP  = MMIO_BASE + 32'hC;
    localparam logic [31:0] ADDR_TCTRL = MMIO_BASE + 32'h10;

    // TCTRL bit positions
    localparam int TCTRL_EN    = 0;
    localparam int TCTRL_CLR   = 1;
    localparam int TCTRL_MATCH = 2;

    typedef enum logic [2:0] {
        SEL_RAM   = 3'd0,
        SEL_LED   = 3'd1,
        SEL_SW    = 3'd2,
        SEL_TCNT  = 3'd3,
        SEL_TCMP  = 3'd4,
        SEL_TCTRL = 3'd5,
        SEL_NONE  = 3'd6
    } sel_t;

    // Word-granular decode: the two byte-offset bits never take part, so a
    // misaligned address selects the word that contains it.
    function automatic sel_t addr_decode(input logic [31:0] addr,
                                         input int unsigned ram_words);
        logic [29:0] w_word;
        sel_t        w_sel;
        w_word = addr[31:2];
        w_sel  = SEL_NONE;
        if (w_word < 30'(ram_words))
            w_sel = SEL_RAM;
        else if (w_word == ADDR_LED[31:2])
            w_sel = SEL_LED;
        else if (w_word == ADDR_SW[31:2])
            w_sel = SEL_SW;
        else if (w_word == ADDR_TCNT[31:2])
            w_sel = SEL_TCNT;
        else if (w_word == ADDR_TCMP[31:2])
            w_sel = SEL_TCMP;
        else if (w_word == ADDR_TCTRL[31:2])
            w_sel = SEL_TCTRL;
        // the byte-offset bits are deliberately ignored
        if (addr[1:0] != 2'b00)
            w_sel = w_sel;
        return w_sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_mmio_timer.sv
`default_nettype none
// ============================================================================
// Module      : mmio_timer
// Description : Compare/match timer behind the TCNT, TCMP and TCTRL registers.
//               Counts while EN is set; when the count equals the compare
//               value the sticky MATCH flag is set and the count either
//               clears (CLR_ON_MATCH) or keeps incrementing.
// Ports       : clk, reset (async, active-low)
//               i_wr_tcnt/i_wr_tcmp/i_wr_tctrl : register write strobes
//               i_wdata                        : store data
//               o_tcnt/o_tcmp                  : counter / compare values
//               o_tctrl                        : {MATCH, CLR_ON_MATCH, EN}
//               o_match                        : MATCH flag level
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_timer
    import dmem_mmio_pkg::*;
#(
    parameter int TIMER_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_wr_tcnt,
    input  logic               i_wr_tcmp,
    input  logic               i_wr_tctrl,
    input  logic [31:0]        i_wdata,
    output logic [TIMER_W-1:0] o_tcnt,
    output logic [TIMER_W-1:0] o_tcmp,
    output logic [2:0]         o_tctrl,
    output logic               o_match
);

    logic [TIMER_W-1:0] r_tcnt;
    logic [TIMER_W-1:0] r_tcmp;
    logic               r_en;
    logic               r_clr;
    logic               r_match;
    logic [TIMER_W-1:0] w_wdata;
    logic               w_hit;

    assign w_wdata = i_wdata[TIMER_W-1:0];

    // Uses the EN value currently held, so a TCTRL write only affects later edges.
    assign w_hit = r_en && (r_tcnt == r_tcmp);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tcnt  <= '0;
            r_tcmp  <= '1;
            r_en    <= 1'b0;
            r_clr   <= 1'b0;
            r_match <= 1'b0;
        end else begin
            // CPU write to TCNT beats both increment and clear-on-match
            if (i_wr_tcnt)
                r_tcnt <= w_wdata;
            else if (r_en)
                r_tcnt <= (w_hit && r_clr) ? '0 : r_tcnt + 1'b1;

            if (i_wr_tcmp)
                r_tcmp <= w_wdata;

            if (i_wr_tctrl) begin
                r_en  <= i_wdata[TCTRL_EN];
                r_clr <= i_wdata[TCTRL_CLR];
            end

            // a new match outranks a simultaneous write-1-to-clear
            if (w_hit)
                r_match <= 1'b1;
            else if (i_wr_tctrl && i_wdata[TCTRL_MATCH])
                r_match <= 1'b0;
        end
    end

    assign o_tcnt  = r_tcnt;
    assign o_tcmp  = r_tcmp;
    assign o_tctrl = {r_match, r_clr, r_en};
    assign o_match = r_match;

endmodule
`default_nettype wire

// File: rtl/dmem_mmio.sv
`default_nettype none
// ============================================================================
// Module      : dmem_mmio
// Description : Data-memory stage for the single-cycle datapath. Word RAM plus
//               an MMIO window holding an LED register, synchronised switches
//               and a compare/match timer. Reads are combinational from Addr;
//               writes land on the rising clock edge when MemWrite is high.
// Ports       : clk, reset (async, active-low)
//               MemWrite, Addr, WriteData : store/load request
//               ReadData                  : combinational load data
//               sw                        : asynchronous switch inputs
//               led                       : LED register
//               timer_match               : timer MATCH flag
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_mmio
    import dmem_mmio_pkg::*;
#(
    parameter int RAM_WORDS = 64,
    parameter int TIMER_W   = 32,
    parameter int SW_W      = 10,
    parameter int LED_W     = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MemWrite,
    input  logic [31:0]      Addr,
    input  logic [31:0]      WriteData,
    output logic [31:0]      ReadData,
    input  logic [SW_W-1:0]  sw,
    output logic [LED_W-1:0] led,
    output logic             timer_match
);

    localparam int c_ram_aw = $clog2(RAM_WORDS);

    sel_t               w_sel;
    logic [31:0]        r_ram [RAM_WORDS];
    logic [LED_W-1:0]   r_led;
    logic [SW_W-1:0]    r_sw_meta;
    logic [SW_W-1:0]    r_sw_sync;
    logic [TIMER_W-1:0] w_tcnt;
    logic [TIMER_W-1:0] w_tcmp;
    logic [2:0]         w_tctrl;
    logic               w_match;

    assign w_sel = addr_decode(Addr, RAM_WORDS);

    // RAM has no reset; contents are undefined until first written.
    always_ff @(posedge clk) begin
        if (MemWrite && (w_sel == SEL_RAM))
            r_ram[Addr[c_ram_aw+1:2]] <= WriteData;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_led <= '0;
        else if (MemWrite && (w_sel == SEL_LED))
            r_led <= WriteData[LED_W-1:0];
    end

    // Two-flop synchroniser on the asynchronous switch inputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sw_meta <= '0;
            r_sw_sync <= '0;
        end else begin
            r_sw_meta <= sw;
            r_sw_sync <= r_sw_meta;
        end
    end

    mmio_timer #(
        .TIMER_W (TIMER_W)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .i_wr_tcnt  (MemWrite && (w_sel == SEL_TCNT)),
        .i_wr_tcmp  (MemWrite && (w_sel == SEL_TCMP)),
        .i_wr_tctrl (MemWrite && (w_sel == SEL_TCTRL)),
        .i_wdata    (WriteData),
        .o_tcnt     (w_tcnt),
        .o_tcmp     (w_tcmp),
        .o_tctrl    (w_tctrl),
        .o_match    (w_match)
    );

    // Load mux reads pre-edge state, so a store shows up only on later reads.
    always_comb begin
        ReadData = '0;
        case (w_sel)
            SEL_RAM:   ReadData = r_ram[Addr[c_ram_aw+1:2]];
            SEL_LED:   ReadData = 32'(r_led);
            SEL_SW:    ReadData = 32'(r_sw_sync);
            SEL_TCNT:  ReadData = 32'(w_tcnt);
            SEL_TCMP:  ReadData = 32'(w_tcmp);
            SEL_TCTRL: ReadData = {29'd0, w_tctrl};
            default:   ReadData = '0;
        endcase
    end

    assign led         = r_led;
    assign timer_match = w_match;

endmodule
`default_nettype wire
